// File: rtl/elevator_if.sv
// Elevator controller signal bundle: request/tick inputs from the building
// side and motor/door/status outputs from the controller.
interface elevator_if #(
    parameter int NUM_FLOORS = 4
) ();
    localparam int FW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;

    logic                  step_tick;
    logic [NUM_FLOORS-1:0] call;
    logic                  DIR;
    logic                  RUN;
    logic [FW-1:0]         floor;
    logic                  door_open;
    logic [NUM_FLOORS-1:0] pending;

    // Building side: drives buttons and motor step ticks, observes status.
    modport master (
        output step_tick,
        output call,
        input  DIR,
        input  RUN,
        input  floor,
        input  door_open,
        input  pending
    );

    // Controller side.
    modport slave (
        input  step_tick,
        input  call,
        output DIR,
        output RUN,
        output floor,
        output door_open,
        output pending
    );
endinterface

// File: rtl/elevator_controller.sv
// Single-cab elevator controller. Latches floor calls, drives a stepper motor
// FSM (RUN/DIR) and the doors. Requests are served with a sweep policy:
// keep going in the last travel direction while there is work ahead, then
// reverse. Position inside a floor span is tracked in motor steps.
module elevator_controller #(
    parameter int NUM_FLOORS      = 4,
    parameter int STEPS_PER_FLOOR = 512,
    parameter int DOOR_TICKS      = 64
) (
    input  logic      CLK,
    input  logic      reset_n,
    elevator_if.slave bus
);
    localparam int FW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
    localparam int CW = (STEPS_PER_FLOOR > 1) ? $clog2(STEPS_PER_FLOOR) : 1;
    localparam int TW = $clog2(DOOR_TICKS + 1);

    localparam logic [CW-1:0] STEP_LAST = CW'(STEPS_PER_FLOOR - 1);
    localparam logic [CW-1:0] STEP_ONE  = CW'(1);
    localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } state_t;

    state_t                state_reg;
    logic [FW-1:0]         floor_reg;
    logic [CW-1:0]         step_cnt_reg;
    logic [TW-1:0]         door_timer_reg;
    logic [NUM_FLOORS-1:0] pending_reg;
    logic                  dir_reg;
    logic                  run_reg;
    logic                  door_open_reg;
    logic                  last_dir_reg;

    // Per-floor views relative to the cab position.
    logic [NUM_FLOORS-1:0] here_onehot;    // floor_reg
    logic [NUM_FLOORS-1:0] up_onehot;      // floor_reg + 1 (arrival floor when climbing)
    logic [NUM_FLOORS-1:0] req_above;      // pending strictly above floor_reg
    logic [NUM_FLOORS-1:0] req_below;      // pending strictly below floor_reg
    logic [NUM_FLOORS-1:0] req_beyond_up;  // pending strictly above floor_reg + 1

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            assign here_onehot[gi]   = (int'(floor_reg) == gi);
            assign up_onehot[gi]     = (int'(floor_reg) + 1 == gi);
            assign req_above[gi]     = pending_reg[gi] && (gi > int'(floor_reg));
            assign req_below[gi]     = pending_reg[gi] && (gi < int'(floor_reg));
            assign req_beyond_up[gi] = pending_reg[gi] && (gi > int'(floor_reg) + 1);
        end
    endgenerate

    logic                  stopped;
    logic                  call_here;
    logic                  pend_here;
    logic                  call_up;
    logic                  pend_up;
    logic                  any_above;
    logic                  any_below;
    logic [NUM_FLOORS-1:0] pending_next;

    // While stopped, a call for the cab's own floor is answered by the door
    // directly, so it never becomes a latched request.
    always_comb begin
        stopped      = (state_reg == IDLE) || (state_reg == DOOR);
        call_here    = |(bus.call & here_onehot);
        pend_here    = |(pending_reg & here_onehot);
        call_up      = |(bus.call & up_onehot);
        pend_up      = |(pending_reg & up_onehot);
        any_above    = |req_above;
        any_below    = |req_below;
        pending_next = pending_reg | (bus.call & ~(stopped ? here_onehot : '0));
    end

    // Main controller FSM: request latching, travel, arrival decisions, door timing.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            floor_reg      <= '0;
            step_cnt_reg   <= '0;
            door_timer_reg <= '0;
            pending_reg    <= '0;
            dir_reg        <= 1'b1;
            run_reg        <= 1'b0;
            door_open_reg  <= 1'b0;
            last_dir_reg   <= 1'b1;
        end else begin
            pending_reg <= pending_next;
            case (state_reg)
                IDLE: begin
                    if (call_here || pend_here) begin
                        state_reg      <= DOOR;
                        door_open_reg  <= 1'b1;
                        door_timer_reg <= '0;
                        pending_reg    <= pending_next & ~here_onehot;
                    end else if (last_dir_reg ? any_above : any_below) begin
                        // Keep sweeping the way we last travelled.
                        state_reg    <= last_dir_reg ? MOVE_UP : MOVE_DOWN;
                        run_reg      <= 1'b1;
                        dir_reg      <= last_dir_reg;
                        step_cnt_reg <= '0;
                    end else if (last_dir_reg ? any_below : any_above) begin
                        // Nothing ahead: reverse. DIR only changes here, with RUN low before.
                        state_reg    <= last_dir_reg ? MOVE_DOWN : MOVE_UP;
                        run_reg      <= 1'b1;
                        dir_reg      <= ~last_dir_reg;
                        last_dir_reg <= ~last_dir_reg;
                        step_cnt_reg <= '0;
                    end
                end

                MOVE_UP: begin
                    if (bus.step_tick) begin
                        if (step_cnt_reg == STEP_LAST) begin
                            // Arrival at floor_reg + 1.
                            step_cnt_reg <= '0;
                            floor_reg    <= floor_reg + 1'b1;
                            if (call_up || pend_up) begin
                                state_reg      <= DOOR;
                                run_reg        <= 1'b0;
                                door_open_reg  <= 1'b1;
                                door_timer_reg <= '0;
                                pending_reg    <= pending_next & ~up_onehot;
                            end else if (!(|req_beyond_up)) begin
                                state_reg <= IDLE;
                                run_reg   <= 1'b0;
                            end
                        end else begin
                            step_cnt_reg <= step_cnt_reg + 1'b1;
                        end
                    end
                end

                MOVE_DOWN: begin
                    if (bus.step_tick) begin
                        if (step_cnt_reg == '0) begin
                            // Leaving a floor: the cab is now above floor_reg - 1.
                            floor_reg    <= floor_reg - 1'b1;
                            step_cnt_reg <= STEP_LAST;
                        end else if (step_cnt_reg == STEP_ONE) begin
                            // Arrival at floor_reg.
                            step_cnt_reg <= '0;
                            if (call_here || pend_here) begin
                                state_reg      <= DOOR;
                                run_reg        <= 1'b0;
                                door_open_reg  <= 1'b1;
                                door_timer_reg <= '0;
                                pending_reg    <= pending_next & ~here_onehot;
                            end else if (!any_below) begin
                                state_reg <= IDLE;
                                run_reg   <= 1'b0;
                            end
                        end else begin
                            step_cnt_reg <= step_cnt_reg - 1'b1;
                        end
                    end
                end

                DOOR: begin
                    if (call_here) begin
                        // Someone pressed this floor again: hold the doors.
                        door_timer_reg <= '0;
                    end else if (bus.step_tick) begin
                        if (door_timer_reg == DOOR_LAST) begin
                            state_reg      <= IDLE;
                            door_open_reg  <= 1'b0;
                            door_timer_reg <= '0;
                        end else begin
                            door_timer_reg <= door_timer_reg + 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    run_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DIR       = dir_reg;
    assign bus.RUN       = run_reg;
    assign bus.floor     = floor_reg;
    assign bus.door_open = door_open_reg;
    assign bus.pending   = pending_reg;
endmodule
